fp_mult_pipe: RTL and testbench
===============================

// Module: fp_mult_pipe
// PURPOSE
//  Parallel, pipelined IEEE-754-style floating-point multiplier with LANES independent lanes.
//  Operand format is parametrisable; round-to-nearest-even; subnormals flushed to zero.
//  Sits between the parallel operand fetch and the accumulate stage.
//  Successor to the fixed-width mult block: adds valid/ready flow control, backpressure,
//  parametrised lane count and format, and explicit special-value handling.
// PARAMETERS
//  LANES   4   number of parallel lanes (replaces global PARALLEL_ORDER)
//  EXP_W   8   exponent field width; bias = 2^(EXP_W-1)-1
//  MAN_W   23  stored mantissa width; word width DW = 1+EXP_W+MAN_W (32 by default)
// PORTS
//  clk        in   1           clock; all state updates on rising edge
//  rst        in   1           synchronous, active-high reset
//  in_valid   in   1           operand bundle valid
//  in_ready   out  1           block accepts a bundle this cycle
//  opa        in   LANES x DW  operand A, packed [LANES-1:0][DW-1:0]
//  opb        in   LANES x DW  operand B, same packing
//  out_valid  out  1           result bundle valid
//  out_ready  in   1           downstream accepts the result
//  out        out  LANES x DW  products, lane i = opa[i]*opb[i]
// BEHAVIOUR
//  - Reset: s1/s2/s3 valid bits = 0, out_valid = 0, out = 0; in_ready = 1 in the cycle after reset.
//  - Handshake: transfer occurs when valid && ready on the same edge. in_ready = adv, where
//    adv = !s3_valid || out_ready. When adv = 0 the whole pipe holds (global stall). out is stable
//    while out_valid && !out_ready. Internal bubbles are not collapsed.
//  - Latency: exactly 3 cycles from accept to out_valid when unstalled; throughput 1 bundle/cycle.
//  - S1: unpack; sign = sa^sb; exp sum = ea+eb-bias (EXP_W+2 bits, signed); classify zero/inf/NaN.
//    Any exponent-0 operand is treated as zero (FTZ).
//  - S2: (MAN_W+1)x(MAN_W+1) mantissa product with hidden 1s.
//  - S3: normalise (product >= 2 -> shift right 1, exp+1); RNE on guard/round/sticky;
//    a rounding carry renormalises. exp >= 2^EXP_W-1 -> +/-inf. exp <= 0 -> signed zero.
//  - Specials: NaN in, or inf*0 -> canonical NaN {0,all-1 exp,1,0...}.
//    inf*finite-nonzero -> signed inf. zero*finite -> signed zero.
//  - Lanes are fully independent; all lanes share the single valid/ready pair.
//  - rst mid-flight: all in-flight bundles are discarded, no partial output.
// CONFIGURATION
//  FP_MULT_FLAGS_EN defined: extra port out_flags out LANES x 4 = {invalid,overflow,underflow,inexact}
//    per lane, pipelined alongside out, reset 0, valid with out_valid.
//  Not defined: port and flag logic absent; numerical results identical.
// STRUCTURE
//  fp_mult_pkg: field-width localparams derived from EXP_W/MAN_W, class enum
//    {ZERO,NORM,INF,NAN}, canonical-NaN function, unpacked-operand struct.
//  fp_mult_lane: one lane's 3-stage datapath with stage enable; instantiated LANES times
//    via generate. Top level holds the valid pipeline, the adv/ready logic and the flag ifdef.
// TESTING (defaults, LANES=4)
//  1. Lane1 0x40A00000*0x40800000 (5*4), others 0 -> 3 cycles later lane1 0x41A00000, others 0x00000000.
//  2. 0xC0000000*0x40400000 -> 0xC0C00000; 0x3FC00000*0x3FC00000 -> 0x40100000.
//  3. 0x7F000000*0x40000000 -> 0x7F800000 (overflow flag set if FLAGS_EN);
//     0x00800000*0x3F000000 -> 0x00000000 (underflow).
//  4. 0x7F800000*0x00000000 -> 0x7FC00000; 0x7FC00001*0x3F800000 -> 0x7FC00000.
//  5. 8 back-to-back bundles, out_ready low cycles 4-6 -> in_ready low while held, out stable,
//     all 8 results in order, no loss or duplication.
//  6. rst asserted with 2 bundles in flight -> out_valid 0 next cycle; the in-flight bundles never appear.

Source files
------------

// File: rtl/fp_mult_pkg.sv
// Shared definitions for the fp_mult_pipe datapath: operand classes, per-operand info
// and helpers that derive format-dependent constants from EXP_W/MAN_W.
package fp_mult_pkg;

  localparam int DEF_EXP_W = 8;
  localparam int DEF_MAN_W = 23;

  // Flag vector layout {invalid, overflow, underflow, inexact}
  localparam int FLAG_W = 4;

  typedef enum logic [1:0] {
    CLS_ZERO = 2'd0,
    CLS_NORM = 2'd1,
    CLS_INF  = 2'd2,
    CLS_NAN  = 2'd3
  } fp_class_e;

  typedef struct packed {
    logic      sign;
    fp_class_e cls;
  } fp_unpacked_t;

  // Subnormals have a zero exponent and are therefore classified as zero.
  function automatic fp_class_e fp_classify(input logic exp_zero, input logic exp_ones,
                                            input logic man_nz);
    fp_class_e c;
    if (exp_zero) begin
      c = CLS_ZERO;
    end else if (!exp_ones) begin
      c = CLS_NORM;
    end else if (man_nz) begin
      c = CLS_NAN;
    end else begin
      c = CLS_INF;
    end
    return c;
  endfunction

  function automatic logic [63:0] fp_canonical_nan(input int exp_w, input int man_w);
    logic [63:0] ones;
    ones = (64'd1 << (exp_w + 1)) - 64'd1;
    return ones << (man_w - 1);
  endfunction

endpackage

// File: rtl/fp_mult_lane.sv
// One lane of the floating-point multiplier: unpack/classify, mantissa product, then
// normalise and round-to-nearest-even. Optional flags with FP_MULT_FLAGS_EN.
module fp_mult_lane
  import fp_mult_pkg::*;
#(
  parameter int  EXP_W = DEF_EXP_W,
  parameter int  MAN_W = DEF_MAN_W,
  localparam int DW    = 1 + EXP_W + MAN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic [DW-1:0]     a_i,
  input  logic [DW-1:0]     b_i,
`ifdef FP_MULT_FLAGS_EN
  output logic [FLAG_W-1:0] flags_o,
`endif
  output logic [DW-1:0]     res_o
);

  localparam int EW2 = EXP_W + 2;
  localparam int SW  = MAN_W + 1;
  localparam int PW  = 2 * SW;
  localparam logic signed [EW2-1:0] BIAS = EW2'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW2-1:0] EMAX = EW2'((1 << EXP_W) - 1);
  localparam logic [63:0]   CNAN_W = fp_canonical_nan(EXP_W, MAN_W);
  localparam logic [DW-1:0] CNAN   = CNAN_W[DW-1:0];

  fp_unpacked_t             ua, ub;
  logic [EXP_W-1:0]         ea, eb;
  logic                     sign_d, spec_d;
  logic [DW-1:0]            spec_val_d;
  logic signed [EW2-1:0]    esum_d;
  logic [SW-1:0]            siga_d, sigb_d;

  logic                     sign1_q, spec1_q;
  logic [DW-1:0]            spec_val1_q;
  logic signed [EW2-1:0]    esum1_q;
  logic [SW-1:0]            siga_q, sigb_q;

  logic [PW-1:0]            prod_d, prod_q;
  logic                     sign2_q, spec2_q;
  logic [DW-1:0]            spec_val2_q;
  logic signed [EW2-1:0]    esum2_q;

  logic [PW-2:0]            pn;
  logic [MAN_W-1:0]         man;
  logic                     g, st, rnd, ovf, unf;
  logic [MAN_W:0]           sig_r;
  logic signed [EW2-1:0]    e_norm, e_fin;
  logic [DW-1:0]            res_d, res_q;

  // Stage 1: unpack, classify and resolve special-value results early
  always_comb begin
    ea         = a_i[DW-2 -: EXP_W];
    eb         = b_i[DW-2 -: EXP_W];
    ua.sign    = a_i[DW-1];
    ub.sign    = b_i[DW-1];
    ua.cls     = fp_classify(ea == '0, ea == '1, a_i[MAN_W-1:0] != '0);
    ub.cls     = fp_classify(eb == '0, eb == '1, b_i[MAN_W-1:0] != '0);
    sign_d     = ua.sign ^ ub.sign;
    esum_d     = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;
    siga_d     = {1'b1, a_i[MAN_W-1:0]};
    sigb_d     = {1'b1, b_i[MAN_W-1:0]};
    spec_d     = 1'b1;
    spec_val_d = CNAN;
    if (ua.cls == CLS_NAN || ub.cls == CLS_NAN) begin
      spec_val_d = CNAN;
    end else if ((ua.cls == CLS_INF && ub.cls == CLS_ZERO) ||
                 (ua.cls == CLS_ZERO && ub.cls == CLS_INF)) begin
      spec_val_d = CNAN;
    end else if (ua.cls == CLS_INF || ub.cls == CLS_INF) begin
      spec_val_d = {sign_d, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (ua.cls == CLS_ZERO || ub.cls == CLS_ZERO) begin
      spec_val_d = {sign_d, {(DW-1){1'b0}}};
    end else begin
      spec_d = 1'b0;
    end
  end

  // Stage 2: full significand product including hidden ones
  always_comb begin
    prod_d = PW'(siga_q) * PW'(sigb_q);
  end

  // Stage 3: normalise, RNE round, renormalise on carry, then range check
  always_comb begin
    pn     = prod_q[PW-1] ? prod_q[PW-2:0] : {prod_q[PW-3:0], 1'b0};
    e_norm = esum2_q + $signed({{(EW2-1){1'b0}}, prod_q[PW-1]});
    man    = pn[PW-2 -: MAN_W];
    g      = pn[PW-2-MAN_W];
    st     = |pn[PW-3-MAN_W:0];
    rnd    = g & (st | man[0]);
    sig_r  = {1'b0, man} + {{MAN_W{1'b0}}, rnd};
    e_fin  = e_norm + $signed({{(EW2-1){1'b0}}, sig_r[MAN_W]});
    ovf    = (e_fin >= EMAX);
    unf    = (e_fin <= $signed({EW2{1'b0}}));
    if (spec2_q) begin
      res_d = spec_val2_q;
    end else if (ovf) begin
      res_d = {sign2_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (unf) begin
      res_d = {sign2_q, {(DW-1){1'b0}}};
    end else begin
      res_d = {sign2_q, e_fin[EXP_W-1:0], sig_r[MAN_W-1:0]};
    end
  end

  // Pipeline registers; the whole lane holds when en_i is low
  always_ff @(posedge clk) begin
    if (rst) begin
      sign1_q     <= 1'b0;
      spec1_q     <= 1'b0;
      spec_val1_q <= '0;
      esum1_q     <= '0;
      siga_q      <= '0;
      sigb_q      <= '0;
      prod_q      <= '0;
      sign2_q     <= 1'b0;
      spec2_q     <= 1'b0;
      spec_val2_q <= '0;
      esum2_q     <= '0;
      res_q       <= '0;
    end else if (en_i) begin
      sign1_q     <= sign_d;
      spec1_q     <= spec_d;
      spec_val1_q <= spec_val_d;
      esum1_q     <= esum_d;
      siga_q      <= siga_d;
      sigb_q      <= sigb_d;
      prod_q      <= prod_d;
      sign2_q     <= sign1_q;
      spec2_q     <= spec1_q;
      spec_val2_q <= spec_val1_q;
      esum2_q     <= esum1_q;
      res_q       <= res_d;
    end
  end

  assign res_o = res_q;

`ifdef FP_MULT_FLAGS_EN
  logic              inv_d, inv1_q, inv2_q;
  logic [FLAG_W-1:0] flags_d, flags_q;

  // Flags: invalid only for inf*0; numeric flags only for non-special operands
  always_comb begin
    inv_d = (ua.cls == CLS_INF && ub.cls == CLS_ZERO) ||
            (ua.cls == CLS_ZERO && ub.cls == CLS_INF);
    if (spec2_q) begin
      flags_d = {inv2_q, 3'b000};
    end else begin
      flags_d = {1'b0, ovf, unf, g | st | ovf | unf};
    end
  end

  // Flag pipeline travels in lockstep with the datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      inv1_q  <= 1'b0;
      inv2_q  <= 1'b0;
      flags_q <= '0;
    end else if (en_i) begin
      inv1_q  <= inv_d;
      inv2_q  <= inv1_q;
      flags_q <= flags_d;
    end
  end

  assign flags_o = flags_q;
`endif

endmodule

// File: rtl/fp_mult_pipe.sv
// LANES-wide pipelined FP multiplier with a shared valid/ready pair and global stall.
// Define FP_MULT_FLAGS_EN to add the per-lane out_flags port.
module fp_mult_pipe
  import fp_mult_pkg::*;
#(
  parameter int  LANES = 4,
  parameter int  EXP_W = DEF_EXP_W,
  parameter int  MAN_W = DEF_MAN_W,
  localparam int DW    = 1 + EXP_W + MAN_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [LANES-1:0][DW-1:0]      opa,
  input  logic [LANES-1:0][DW-1:0]      opb,
  output logic                          out_valid,
  input  logic                          out_ready,
`ifdef FP_MULT_FLAGS_EN
  output logic [LANES-1:0][FLAG_W-1:0]  out_flags,
`endif
  output logic [LANES-1:0][DW-1:0]      out
);

  logic adv;
  logic v1_q, v2_q, v3_q;

  // Bubbles are not collapsed: the pipe only moves when the output slot frees up
  assign adv       = !v3_q || out_ready;
  assign in_ready  = adv;
  assign out_valid = v3_q;

  // Valid bits march with the datapath; reset discards everything in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
    end else if (adv) begin
      v1_q <= in_valid;
      v2_q <= v1_q;
      v3_q <= v2_q;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    fp_mult_lane #(
      .EXP_W (EXP_W),
      .MAN_W (MAN_W)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .en_i    (adv),
      .a_i     (opa[i]),
      .b_i     (opb[i]),
`ifdef FP_MULT_FLAGS_EN
      .flags_o (out_flags[i]),
`endif
      .res_o   (out[i])
    );
  end

endmodule

// File: tb/tb_fp_mult_pipe.sv
// Self-checking bench for fp_mult_pipe: directed vectors, random streams with
// backpressure against an integer-arithmetic reference model, and mid-flight reset.
module tb_fp_mult_pipe;

  localparam int LANES = 4;
  localparam int DW    = 32;
  typedef logic [LANES-1:0][DW-1:0] bundle_t;

  logic    clk = 1'b0;
  logic    rst = 1'b1;
  logic    in_valid = 1'b0;
  logic    in_ready;
  logic    out_valid;
  logic    out_ready = 1'b1;
  bundle_t opa = '0;
  bundle_t opb = '0;
  bundle_t out;
`ifdef FP_MULT_FLAGS_EN
  logic [LANES-1:0][3:0] out_flags;
`endif

  int errors = 0;
  int checks = 0;
  bundle_t exp_q[$];

  fp_mult_pipe #(.LANES(LANES), .EXP_W(8), .MAN_W(23)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opa       (opa),
    .opb       (opb),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef FP_MULT_FLAGS_EN
    .out_flags (out_flags),
`endif
    .out       (out)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Reference: exact integer product, rounded to nearest-even, FTZ on both ends
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic s;
    int ea, eb, e, sh;
    bit an, bn, ai, bi, az, bz;
    longint unsigned ma, mb, p, q, rem, half;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    an = (ea == 255) && (a[22:0] != 23'd0);
    bn = (eb == 255) && (b[22:0] != 23'd0);
    ai = (ea == 255) && (a[22:0] == 23'd0);
    bi = (eb == 255) && (b[22:0] == 23'd0);
    az = (ea == 0);
    bz = (eb == 0);
    if (an || bn || (ai && bz) || (bi && az)) return 32'h7FC00000;
    if (ai || bi) return {s, 8'hFF, 23'd0};
    if (az || bz) return {s, 31'd0};
    ma = 64'(a[22:0]) + (64'd1 << 23);
    mb = 64'(b[22:0]) + (64'd1 << 23);
    p  = ma * mb;
    e  = ea + eb - 127;
    if (p >= (64'd1 << 47)) begin
      sh = 24;
      e  = e + 1;
    end else begin
      sh = 23;
    end
    q    = p >> sh;
    rem  = p - (q << sh);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && q[0])) q = q + 64'd1;
    if (q == (64'd1 << 24)) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e >= 255) return {s, 8'hFF, 23'd0};
    if (e <= 0) return {s, 31'd0};
    return {s, 8'(e), q[22:0]};
  endfunction

  function automatic bundle_t ref_bundle(input bundle_t a, input bundle_t b);
    bundle_t r;
    for (int i = 0; i < LANES; i++) r[i] = ref_mul(a[i], b[i]);
    return r;
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] v;
    case ($urandom_range(0, 9))
      0: v = $urandom;
      1: begin
        case ($urandom_range(0, 6))
          0: v = 32'h00000000;
          1: v = 32'h80000000;
          2: v = 32'h7F800000;
          3: v = 32'hFF800000;
          4: v = 32'h7FC00000;
          5: v = 32'h7F800001;
          default: v = 32'h00000001;
        endcase
      end
      default: v = {1'($urandom), 8'($urandom_range(60, 194)), 23'($urandom)};
    endcase
    return v;
  endfunction

  function automatic bundle_t rand_bundle();
    bundle_t r;
    for (int i = 0; i < LANES; i++) r[i] = rand_op();
    return r;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Drives one bundle, then reports whether out_valid rose early and what appeared at 3 cycles
  task automatic apply_vec(input bundle_t a, input bundle_t b, output bundle_t got,
                           output logic early, output logic late);
    opa = a; opb = b; in_valid = 1'b1; out_ready = 1'b1;
    cyc();
    in_valid = 1'b0; opa = '0; opb = '0;
    cyc();
    early = out_valid;
    cyc();
    late = out_valid;
    got  = out;
    cyc();
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) cyc();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++;
    if (out !== '0) begin errors++; $display("FAIL reset_out got=%h exp=0", out); end
`ifdef FP_MULT_FLAGS_EN
    checks++;
    if (out_flags !== '0) begin errors++; $display("FAIL reset_flags got=%h exp=0", out_flags); end
`endif
    rst = 1'b0;
    cyc();
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_basic();
    bundle_t a[2], b[2], e[2], got;
    logic early, late;
    a[0] = {32'h0, 32'h0, 32'h40A00000, 32'h0};
    b[0] = {32'h0, 32'h0, 32'h40800000, 32'h0};
    e[0] = {32'h0, 32'h0, 32'h41A00000, 32'h0};
    a[1] = {32'h80000000, 32'h3F800000, 32'h3FC00000, 32'hC0000000};
    b[1] = {32'h3F800000, 32'h3F800000, 32'h3FC00000, 32'h40400000};
    e[1] = {32'h80000000, 32'h3F800000, 32'h40100000, 32'hC0C00000};
    for (int v = 0; v < 2; v++) begin
      apply_vec(a[v], b[v], got, early, late);
      checks++;
      if (early !== 1'b0) begin errors++; $display("FAIL basic_latency_early v%0d got=%b exp=0", v, early); end
      checks++;
      if (late !== 1'b1) begin errors++; $display("FAIL basic_latency v%0d got=%b exp=1", v, late); end
      for (int i = 0; i < LANES; i++) begin
        checks++;
        if (got[i] !== e[v][i]) begin
          errors++; $display("FAIL basic v%0d lane%0d got=%h exp=%h", v, i, got[i], e[v][i]);
        end
      end
    end
  endtask

  task automatic test_specials();
    bundle_t a[2], b[2], e[2], got;
    logic early, late;
    a[0] = {32'h7FC00001, 32'h7F800000, 32'h00800000, 32'h7F000000};
    b[0] = {32'h3F800000, 32'h00000000, 32'h3F000000, 32'h40000000};
    e[0] = {32'h7FC00000, 32'h7FC00000, 32'h00000000, 32'h7F800000};
    a[1] = {32'hBF800000, 32'h80000000, 32'h00400000, 32'hFF800000};
    b[1] = {32'h7F800000, 32'h7F800000, 32'h3F800000, 32'h40000000};
    e[1] = {32'hFF800000, 32'h7FC00000, 32'h00000000, 32'hFF800000};
    for (int v = 0; v < 2; v++) begin
      apply_vec(a[v], b[v], got, early, late);
      checks++;
      if (late !== 1'b1) begin errors++; $display("FAIL special_valid v%0d got=%b exp=1", v, late); end
      for (int i = 0; i < LANES; i++) begin
        checks++;
        if (got[i] !== e[v][i]) begin
          errors++; $display("FAIL special v%0d lane%0d got=%h exp=%h", v, i, got[i], e[v][i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    bundle_t ca, cb, prev_out, e;
    int sent = 0, got = 0, n = 0;
    logic prev_hold = 1'b0;
    exp_q.delete();
    ca = rand_bundle(); cb = rand_bundle(); prev_out = '0;
    while (got < 8 && n < 100) begin
      out_ready = !(n >= 4 && n <= 6);
      in_valid  = (sent < 8);
      opa = ca; opb = cb;
      #1;
      checks++;
      if (in_ready !== (!out_valid || out_ready)) begin
        errors++; $display("FAIL b2b_in_ready cyc%0d got=%b exp=%b", n, in_ready, !out_valid || out_ready);
      end
      if (prev_hold) begin
        checks++;
        if (out !== prev_out) begin errors++; $display("FAIL b2b_stable cyc%0d got=%h exp=%h", n, out, prev_out); end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL b2b_spurious cyc%0d got=%h exp=none", n, out);
        end else begin
          e = exp_q.pop_front();
          if (out !== e) begin errors++; $display("FAIL b2b_data #%0d got=%h exp=%h", got, out, e); end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_bundle(ca, cb));
        sent++;
        ca = rand_bundle(); cb = rand_bundle();
      end
      prev_hold = out_valid && !out_ready;
      prev_out  = out;
      cyc();
      n++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++;
    if (got != 8) begin errors++; $display("FAIL b2b_count got=%0d exp=8", got); end
  endtask

  task automatic test_random();
    bundle_t ca, cb, prev_out, e;
    int sent = 0, got = 0, n = 0;
    logic prev_hold = 1'b0;
    exp_q.delete();
    ca = rand_bundle(); cb = rand_bundle(); prev_out = '0;
    while (got < 60 && n < 2000) begin
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = (sent < 60) && ($urandom_range(0, 3) != 0);
      opa = ca; opb = cb;
      #1;
      checks++;
      if (in_ready !== (!out_valid || out_ready)) begin
        errors++; $display("FAIL rand_in_ready cyc%0d got=%b exp=%b", n, in_ready, !out_valid || out_ready);
      end
      if (prev_hold) begin
        checks++;
        if (out !== prev_out) begin errors++; $display("FAIL rand_stable cyc%0d got=%h exp=%h", n, out, prev_out); end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rand_spurious cyc%0d got=%h exp=none", n, out);
        end else begin
          e = exp_q.pop_front();
          if (out !== e) begin errors++; $display("FAIL rand_data #%0d got=%h exp=%h", got, out, e); end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_bundle(ca, cb));
        sent++;
        ca = rand_bundle(); cb = rand_bundle();
      end
      prev_hold = out_valid && !out_ready;
      prev_out  = out;
      cyc();
      n++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++;
    if (got != 60) begin errors++; $display("FAIL rand_count got=%0d exp=60", got); end
  endtask

  task automatic test_reset_flight();
    out_ready = 1'b1;
    opa = {32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
    opb = opa;
    in_valid = 1'b1;
    cyc();
    opa = {32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
    opb = opa;
    cyc();
    in_valid = 1'b0; opa = '0; opb = '0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL flight_rst_valid got=%b exp=0", out_valid); end
    checks++;
    if (out !== '0) begin errors++; $display("FAIL flight_rst_out got=%h exp=0", out); end
    for (int k = 0; k < 6; k++) begin
      cyc();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL flight_ghost cyc%0d got=%b exp=0", k, out_valid); end
    end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL flight_in_ready got=%b exp=1", in_ready); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_specials();
    test_back_to_back();
    test_random();
    test_reset_flight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
